// File: rtl/qspi_arb.sv
// qspi_arb: arbiter and sequencer in front of the shared QSPI memory controller.
//
// Three line-transfer requesters (icache fill, dcache fill/writeback, DMA/loader)
// compete for one QSPI controller. One owner is selected in IDLE. The request and
// address attributes are latched and held for the whole line transfer. A one-cycle
// done pulse goes back to the owner. A chip-select gap of GAP_CYCLES follows each
// transfer before the next arbitration.
//
// Optional feature macro: QSPI_ARB_AGE_EN
//   When defined, the icache and DMA ports each keep an age counter. A port that has
//   lost AGE_LIMIT arbitrations beats the dcache. When undefined, strict priority
//   d > i > x applies.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   i_req/i_tag/i_mem          - icache fill request, line address, memory select
//   d_req/d_write/d_tag/d_mem  - dcache request (write = push), line address, memory select
//   x_req/x_write/x_tag/x_mem  - DMA request, direction, line address, memory select
//   i_gnt/d_gnt/x_gnt          - owner indication (one-hot or zero)
//   i_done/d_done/x_done       - one-cycle completion pulse to the owner
//   q_req/q_i_d/q_write/q_mem/q_paddr - registered request to qspi
//   q_done                     - qspi line-complete strobe
module qspi_arb #(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int AGE_LIMIT   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [PA-1:$clog2(LINE_LENGTH)] i_tag,
  input  logic [1:0]                      i_mem,
  input  logic                            d_req,
  input  logic                            d_write,
  input  logic [PA-1:$clog2(LINE_LENGTH)] d_tag,
  input  logic [1:0]                      d_mem,
  input  logic                            x_req,
  input  logic                            x_write,
  input  logic [PA-1:$clog2(LINE_LENGTH)] x_tag,
  input  logic [1:0]                      x_mem,
  output logic                            i_gnt,
  output logic                            d_gnt,
  output logic                            x_gnt,
  output logic                            i_done,
  output logic                            d_done,
  output logic                            x_done,
  output logic                            q_req,
  output logic                            q_i_d,
  output logic                            q_write,
  output logic [1:0]                      q_mem,
  output logic [PA-1:$clog2(LINE_LENGTH)] q_paddr,
  input  logic                            q_done
);

  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Parameter range checks, evaluated at elaboration only.
  generate
    if (GAP_CYCLES < 1 || GAP_CYCLES > 7) begin : g_bad_gap
      $error("qspi_arb: GAP_CYCLES must be in 1..7");
    end
    if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_bad_age
      $error("qspi_arb: AGE_LIMIT must be in 1..15");
    end
  endgenerate

  state_t state_r, state_nxt_s;
  logic [2:0] gap_cnt_r, gap_nxt_s;

  // Grant/done vectors use bit 0 = d, bit 1 = i, bit 2 = x.
  logic [2:0] gnt_r, gnt_s;
  logic [2:0] done_r, done_s;
  logic [2:0] win_s;
  logic       any_req_s;
  logic       i_old_s, x_old_s;

  logic                            q_req_r, q_req_s;
  logic                            q_i_d_r, q_i_d_s;
  logic                            q_write_r, q_write_s;
  logic [1:0]                      q_mem_r, q_mem_s;
  logic [PA-1:$clog2(LINE_LENGTH)] q_paddr_r, q_paddr_s;

  assign any_req_s = d_req | i_req | x_req;

`ifdef QSPI_ARB_AGE_EN
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [3:0] age_i_r, age_x_r;

  // Age counters: bump on a lost arbitration, clear on grant or when idle without a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_i_r <= 4'd0;
      age_x_r <= 4'd0;
    end else if (state_r == IDLE) begin
      if (!i_req || win_s[1]) begin
        age_i_r <= 4'd0;
      end else if (age_i_r != AGE_MAX) begin
        age_i_r <= age_i_r + 4'd1;
      end else begin
        age_i_r <= age_i_r;
      end
      if (!x_req || win_s[2]) begin
        age_x_r <= 4'd0;
      end else if (age_x_r != AGE_MAX) begin
        age_x_r <= age_x_r + 4'd1;
      end else begin
        age_x_r <= age_x_r;
      end
    end else begin
      age_i_r <= age_i_r;
      age_x_r <= age_x_r;
    end
  end

  assign i_old_s = i_req && (age_i_r == AGE_MAX);
  assign x_old_s = x_req && (age_x_r == AGE_MAX);
`else
  assign i_old_s = 1'b0;
  assign x_old_s = 1'b0;
`endif

  // Winner selection: a promoted (aged) port first, x before i; otherwise d > i > x.
  always_comb begin
    win_s = 3'b000;
    if (x_old_s) begin
      win_s = 3'b100;
    end else if (i_old_s) begin
      win_s = 3'b010;
    end else if (d_req) begin
      win_s = 3'b001;
    end else if (i_req) begin
      win_s = 3'b010;
    end else if (x_req) begin
      win_s = 3'b100;
    end else begin
      win_s = 3'b000;
    end
  end

  // State register, gap counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      gap_cnt_r <= 3'd0;
      gnt_r     <= 3'b000;
      done_r    <= 3'b000;
      q_req_r   <= 1'b0;
      q_i_d_r   <= 1'b0;
      q_write_r <= 1'b0;
      q_mem_r   <= 2'd0;
      q_paddr_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_nxt_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      q_req_r   <= q_req_s;
      q_i_d_r   <= q_i_d_s;
      q_write_r <= q_write_s;
      q_mem_r   <= q_mem_s;
      q_paddr_r <= q_paddr_s;
    end
  end

  // Next-state logic; the gap counter is loaded so that GAP lasts GAP_CYCLES cycles.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (q_done) begin
          state_nxt_s = GAP;
          gap_nxt_s   = GAP_LOAD;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      GAP: begin
        if (gap_cnt_r == 3'd0) begin
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s = gap_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gap_nxt_s   = 3'd0;
      end
    endcase
  end

  // Next values of the registered outputs: latch on grant, hold through BUSY, clear after.
  always_comb begin
    gnt_s     = 3'b000;
    done_s    = 3'b000;
    q_req_s   = 1'b0;
    q_i_d_s   = 1'b0;
    q_write_s = 1'b0;
    q_mem_s   = 2'd0;
    q_paddr_s = '0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          gnt_s   = win_s;
          q_req_s = 1'b1;
          if (win_s[0]) begin
            q_write_s = d_write;
            q_mem_s   = d_mem;
            q_paddr_s = d_tag;
          end else if (win_s[1]) begin
            q_i_d_s   = 1'b1;
            q_mem_s   = i_mem;
            q_paddr_s = i_tag;
          end else begin
            q_write_s = x_write;
            q_mem_s   = x_mem;
            q_paddr_s = x_tag;
          end
        end else begin
          gnt_s = 3'b000;
        end
      end
      BUSY: begin
        if (q_done) begin
          done_s = gnt_r;
        end else begin
          gnt_s     = gnt_r;
          q_req_s   = q_req_r;
          q_i_d_s   = q_i_d_r;
          q_write_s = q_write_r;
          q_mem_s   = q_mem_r;
          q_paddr_s = q_paddr_r;
        end
      end
      GAP: begin
        gnt_s = 3'b000;
      end
      default: begin
        gnt_s = 3'b000;
      end
    endcase
  end

  assign d_gnt   = gnt_r[0];
  assign i_gnt   = gnt_r[1];
  assign x_gnt   = gnt_r[2];
  assign d_done  = done_r[0];
  assign i_done  = done_r[1];
  assign x_done  = done_r[2];
  assign q_req   = q_req_r;
  assign q_i_d   = q_i_d_r;
  assign q_write = q_write_r;
  assign q_mem   = q_mem_r;
  assign q_paddr = q_paddr_r;

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed bench for qspi_arb with a transaction-level reference model.
// The model tracks the current owner, the latched attributes, the remaining gap
// time and the per-port ages, and the expected outputs are derived from those.
module tb_qspi_arb;

  localparam int PA  = 24;
  localparam int LL  = 4;
  localparam int TW  = 22;
  localparam int GAP = 1;
  localparam int AGE = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [TW-1:0] i_tag = '0;
  logic [1:0]    i_mem = 2'd0;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [TW-1:0] d_tag = '0;
  logic [1:0]    d_mem = 2'd0;
  logic          x_req = 1'b0;
  logic          x_write = 1'b0;
  logic [TW-1:0] x_tag = '0;
  logic [1:0]    x_mem = 2'd0;
  logic          q_done = 1'b0;
  logic          i_gnt, d_gnt, x_gnt, i_done, d_done, x_done;
  logic          q_req, q_i_d, q_write;
  logic [1:0]    q_mem;
  logic [TW-1:0] q_paddr;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LL), .GAP_CYCLES(GAP), .AGE_LIMIT(AGE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_mem(i_mem),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_mem(d_mem),
    .x_req(x_req), .x_write(x_write), .x_tag(x_tag), .x_mem(x_mem),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .x_gnt(x_gnt),
    .i_done(i_done), .d_done(d_done), .x_done(x_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem),
    .q_paddr(q_paddr), .q_done(q_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 = d, 1 = i, 2 = x, -1 = none.
  int            m_owner = -1;
  int            m_done = -1;
  int            m_gap = 0;
  int            m_age_i = 0;
  int            m_age_x = 0;
  int            m_wr = 0;
  int            m_mem = 0;
  logic [TW-1:0] m_tag = '0;

  always @(posedge clk) begin : model
    int win;
    if (reset) begin
      m_owner = -1; m_done = -1; m_gap = 0; m_age_i = 0; m_age_x = 0;
    end else begin
      m_done = -1;
      if (m_owner >= 0) begin
        if (q_done) begin
          m_done = m_owner; m_owner = -1; m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (d_req || i_req || x_req) begin
        win = -1;
`ifdef QSPI_ARB_AGE_EN
        if (x_req && m_age_x == AGE) win = 2;
        else if (i_req && m_age_i == AGE) win = 1;
`endif
        if (win < 0) begin
          if (d_req) win = 0;
          else if (i_req) win = 1;
          else win = 2;
        end
        m_age_i = (i_req && win != 1) ? ((m_age_i < AGE) ? m_age_i + 1 : AGE) : 0;
        m_age_x = (x_req && win != 2) ? ((m_age_x < AGE) ? m_age_x + 1 : AGE) : 0;
        m_owner = win;
        case (win)
          0: begin m_tag = d_tag; m_mem = int'(d_mem); m_wr = int'(d_write); end
          1: begin m_tag = i_tag; m_mem = int'(i_mem); m_wr = 0; end
          default: begin m_tag = x_tag; m_mem = int'(x_mem); m_wr = int'(x_write); end
        endcase
      end else begin
        m_age_i = 0; m_age_x = 0;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d_gnt", 32'(d_gnt), 32'(m_owner == 0));
      chk("i_gnt", 32'(i_gnt), 32'(m_owner == 1));
      chk("x_gnt", 32'(x_gnt), 32'(m_owner == 2));
      chk("d_done", 32'(d_done), 32'(m_done == 0));
      chk("i_done", 32'(i_done), 32'(m_done == 1));
      chk("x_done", 32'(x_done), 32'(m_done == 2));
      chk("q_req", 32'(q_req), 32'(m_owner >= 0));
      chk("q_i_d", 32'(q_i_d), 32'(m_owner == 1));
      chk("q_write", 32'(q_write), (m_owner >= 0) ? m_wr : 0);
      chk("q_mem", 32'(q_mem), (m_owner >= 0) ? m_mem : 0);
      chk("q_paddr", 32'(q_paddr), (m_owner >= 0) ? 32'(m_tag) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any grant; who = 0 d, 1 i, 2 x, -1 on timeout.
  task automatic wait_gnt(output int who);
    who = -1;
    for (int t = 0; t < 20; t++) begin
      if (d_gnt) begin who = 0; break; end
      if (i_gnt) begin who = 1; break; end
      if (x_gnt) begin who = 2; break; end
      tick();
    end
    if (who < 0) chk("gnt_timeout", 32'd1, 32'd0);
  endtask

  int got[6];
  int exp_win[6];
  int w;

  initial begin
`ifdef QSPI_ARB_AGE_EN
    exp_win = '{0, 0, 0, 0, 2, 0};
`else
    exp_win = '{0, 0, 0, 0, 0, 0};
`endif
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_q_req", 32'(q_req), 32'd0);
    chk("rst_q_paddr", 32'(q_paddr), 32'd0);
    reset = 1'b0;
    tick();

    // Single icache fill; this is cycle 0.
    i_req = 1'b1; i_tag = 22'h12345; i_mem = 2'd2;
    tick();                                   // cycle 1
    chk("t1_q_req", 32'(q_req), 32'd1);
    chk("t1_q_i_d", 32'(q_i_d), 32'd1);
    chk("t1_q_paddr", 32'(q_paddr), 32'h12345);
    chk("t1_q_mem", 32'(q_mem), 32'd2);
    i_req = 1'b0;
    repeat (8) tick();                        // cycle 9
    q_done = 1'b1;
    tick();                                   // cycle 10
    q_done = 1'b0;
    chk("t1_i_done", 32'(i_done), 32'd1);
    chk("t1_q_req10", 32'(q_req), 32'd0);
    tick();                                   // cycle 11
    chk("t1_q_req11", 32'(q_req), 32'd0);
    chk("t1_i_done11", 32'(i_done), 32'd0);
    repeat (2) tick();

    // Simultaneous dcache push and icache fill.
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h00010; d_mem = 2'd1;
    i_req = 1'b1; i_tag = 22'h00020; i_mem = 2'd3;
    tick();
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    chk("t2_q_write", 32'(q_write), 32'd1);
    chk("t2_q_paddr", 32'(q_paddr), 32'h00010);
    d_req = 1'b0;
    repeat (3) tick();
    q_done = 1'b1;
    tick();                                   // m+1
    q_done = 1'b0;
    chk("t2_d_done", 32'(d_done), 32'd1);
    tick();                                   // m+2 (IDLE)
    chk("t2_i_gnt_early", 32'(i_gnt), 32'd0);
    tick();                                   // m+3
    chk("t2_i_gnt", 32'(i_gnt), 32'd1);
    chk("t2_i_q_write", 32'(q_write), 32'd0);
    chk("t2_i_q_paddr", 32'(q_paddr), 32'h00020);
    i_req = 1'b0;
    repeat (2) tick();
    q_done = 1'b1;
    tick();
    q_done = 1'b0;
    chk("t2_i_done", 32'(i_done), 32'd1);
    repeat (2) tick();

    // Owner drops its request and changes its tag mid-transfer.
    d_req = 1'b1; d_write = 1'b0; d_tag = 22'h3ABCD; d_mem = 2'd1;
    tick();
    chk("t3_d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0; d_tag = 22'h11111; d_mem = 2'd0; d_write = 1'b1;
    repeat (3) tick();
    chk("t3_q_paddr", 32'(q_paddr), 32'h3ABCD);
    chk("t3_q_mem", 32'(q_mem), 32'd1);
    chk("t3_q_write", 32'(q_write), 32'd0);
    q_done = 1'b1;
    tick();
    q_done = 1'b0;
    chk("t3_d_done", 32'(d_done), 32'd1);
    tick();
    chk("t3_d_done_once", 32'(d_done), 32'd0);
    tick();

    // Reset during BUSY, then stray q_done in IDLE and in GAP.
    x_req = 1'b1; x_write = 1'b1; x_tag = 22'h2AAAA; x_mem = 2'd3;
    tick();
    chk("t4_x_gnt", 32'(x_gnt), 32'd1);
    chk("t4_q_write", 32'(q_write), 32'd1);
    x_req = 1'b0;
    tick();
    reset = 1'b1; q_done = 1'b1;
    tick();
    reset = 1'b0; q_done = 1'b0;
    chk("t4_rst_x_gnt", 32'(x_gnt), 32'd0);
    chk("t4_rst_x_done", 32'(x_done), 32'd0);
    chk("t4_rst_q_paddr", 32'(q_paddr), 32'd0);
    tick();
    q_done = 1'b1;                            // stray in IDLE
    tick();
    q_done = 1'b0;
    chk("t4_idle_stray", 32'(x_done), 32'd0);
    x_req = 1'b1;
    tick();
    x_req = 1'b0;
    tick();
    q_done = 1'b1;
    tick();                                   // m+1, GAP; q_done kept high
    chk("t4_x_done", 32'(x_done), 32'd1);
    tick();                                   // m+2
    q_done = 1'b0;
    chk("t4_gap_stray", 32'(x_done), 32'd0);
    repeat (2) tick();

    // d and x requesting continuously: record six winners.
    d_req = 1'b1; d_write = 1'b0; d_tag = 22'h00100; d_mem = 2'd0;
    x_req = 1'b1; x_write = 1'b0; x_tag = 22'h00200; x_mem = 2'd1;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(w);
      got[k] = w;
      tick();
      q_done = 1'b1;
      tick();
      q_done = 1'b0;
    end
    d_req = 1'b0; x_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t5_winner%0d", k), 32'(got[k]), 32'(exp_win[k]));
    end
    repeat (3) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_arb.md
# qspi_arb

Arbiter and sequencer for the shared QSPI memory controller. Three line-transfer requesters compete for it: the icache fill, the dcache fill/writeback, and an auxiliary DMA/loader port. The block selects one owner, holds the QSPI request and address attributes stable for the whole line transfer, and returns a one-cycle completion pulse to the owner. It sits between the caches and `qspi`, replacing the top-level request OR and the `ifetch ? i_tag : d_tag` mux.

## Interface
Parameters:
- `PA`, 24, physical address width.
- `LINE_LENGTH`, 4, cache line length in bytes. Tags are `[PA-1:$clog2(LINE_LENGTH)]`.
- `GAP_CYCLES`, 1, idle turnaround cycles after each transfer (chip-select high time). Legal range 1..7.
- `AGE_LIMIT`, 4, lost arbitrations before a waiting requester is promoted. Used only with `QSPI_ARB_AGE_EN`; legal range 1..15.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: icache fill request. `i_tag` in PA-log2(LL): line address. `i_mem` in 2: target memory select.
- `d_req` in 1: dcache request. `d_write` in 1: 1 = push (writeback), 0 = pull. `d_tag` in PA-log2(LL). `d_mem` in 2.
- `x_req` in 1: DMA request. `x_write` in 1. `x_tag` in PA-log2(LL). `x_mem` in 2.
- `i_gnt`, `d_gnt`, `x_gnt` out 1 each: owner indication, one-hot or all zero.
- `i_done`, `d_done`, `x_done` out 1 each: one-cycle completion pulse to the owner.
- `q_req` out 1: to `qspi.req`.
- `q_i_d` out 1: to `qspi.i_d`; 1 when the icache owns the transfer.
- `q_write` out 1: to `qspi.write`.
- `q_mem` out 2: to `qspi.mem`.
- `q_paddr` out PA-log2(LL): to `qspi.paddr`.
- `q_done` in 1: from `qspi`; high for exactly one cycle on the final nibble strobe of the line.

## Operation
- States: `IDLE`, `BUSY`, `GAP`. Reset puts the block in `IDLE`.
- Outputs in reset and in `IDLE`: all `*_gnt`, `*_done`, `q_req`, `q_i_d`, `q_write` are 0; `q_mem` = 0; `q_paddr` = 0.
- **IDLE.** When any `*_req` is high, select a winner and go to `BUSY`.
  - The winner's tag, mem and write values are latched into `q_*`.
  - The winner's `*_gnt` is set. `q_i_d` = 1 only for the icache; icache transfers always have `q_write` = 0.
- Priority without ageing: `d` > `i` > `x`.
- **BUSY.**
  - `q_req` = 1. `q_*` and the grant are held constant regardless of requester inputs.
  - On `q_done`: clear `q_req` and the grant, pulse the owner's `*_done` for one cycle, and go to `GAP`.
- **GAP.** Stay for `GAP_CYCLES` cycles, counted by a 3-bit down-counter, then return to `IDLE`.
- A requester dropping `*_req` while it is owner has no effect. The transfer completes and `*_done` still pulses.
- A requester dropping `*_req` before it is granted is simply never granted. This is how fault-cancelled accesses are dropped.
- `q_done` outside `BUSY` is ignored and produces no `*_done`.
- Reset mid-`BUSY`: the next cycle is `IDLE` with all outputs at reset values and no `*_done` pulse. The `qspi` block is reset by the same `reset`.

## Timing
- Request high in `IDLE` at cycle n: grant and `q_req` are high at n+1. All `q_*` outputs are registered.
- `q_done` at cycle m:
  - m+1: `q_req` = 0, grant = 0, `*_done` = 1, state `GAP`.
  - m+1 .. m+GAP_CYCLES: state `GAP`.
  - m+GAP_CYCLES+1: `IDLE`.
  - m+GAP_CYCLES+2: earliest next grant.
- Back-to-back transfers: the minimum request-to-request spacing is GAP_CYCLES+1 cycles of `q_req` low.
- Simultaneous requests resolve in a single `IDLE` cycle. Only one grant is ever active.

## Configuration
- Macro: `QSPI_ARB_AGE_EN`.
- **Defined:** starvation avoidance for the icache and DMA ports.
  - Each of `i` and `x` has a 4-bit age counter.
  - The counter increments, saturating at `AGE_LIMIT`, on every arbitration where its `*_req` was high and it lost.
  - The counter clears when that port is granted, or when its `*_req` is low in `IDLE`.
  - A port whose counter equals `AGE_LIMIT` beats `d`. If both `i` and `x` are saturated, `x` wins.
  - Counters reset to 0.
- **Undefined:** strict priority `d` > `i` > `x`. No counters exist, and `x` can starve indefinitely.

## Test plan
- Single icache fill: `i_req` = 1 with `i_tag` = 0x12345, `i_mem` = 2 at cycle 0 → at cycle 1 `q_req` = 1, `q_i_d` = 1, `q_paddr` = 0x12345, `q_mem` = 2. After `q_done` at cycle 9 → `i_done` = 1 at cycle 10, and `q_req` = 0 for cycles 10-11.
- Simultaneous `d_req` (push, `d_tag` = 0x00010) and `i_req` → `d_gnt` first with `q_write` = 1. After that transfer's `d_done` plus the gap, `i_gnt` follows with `q_write` = 0.
- Owner drops `d_req` mid-`BUSY`, and `d_tag` changes → `q_paddr` stays at the latched value and `d_done` still pulses one cycle after `q_done`.
- Reset asserted during `BUSY` → next cycle all outputs are 0 and no `*_done` pulse appears. A stray `q_done` arriving in `IDLE` or `GAP` produces no pulse.
- With `QSPI_ARB_AGE_EN`, `AGE_LIMIT` = 4: `d_req` and `x_req` held continuously → `d` wins 4 times, `x` wins the 5th arbitration, then `d` resumes. Without the macro, `x` never wins while `d_req` is high.
